// File: rtl/dequant_reconstruct_pkg.sv
// quant_pkg: widths, FSM state type and saturation limit shared across the quantizer path
package quant_pkg;
  localparam int QUOT_WIDTH = 6;
  localparam int STEP_WIDTH = 9;
  localparam int OUT_WIDTH = 10;
  localparam int OUT_MAX = (1 << OUT_WIDTH) - 1;
  typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;
endpackage

// File: rtl/dequant_reconstruct_if.sv
// dequant_reconstruct_if: input pair and output sample handshakes
interface dequant_reconstruct_if
  import quant_pkg::*;
#(
  parameter int QUOT_WIDTH = quant_pkg::QUOT_WIDTH,
  parameter int STEP_WIDTH = quant_pkg::STEP_WIDTH,
  parameter int OUT_WIDTH = quant_pkg::OUT_WIDTH
);
  logic in_valid;
  logic in_ready;
  logic [QUOT_WIDTH-1:0] quotient;
  logic [STEP_WIDTH-1:0] step;
  logic out_valid;
  logic out_ready;
  logic [OUT_WIDTH-1:0] recon;
  logic saturated;
  modport master(output in_valid, quotient, step, out_ready, input in_ready, out_valid, recon, saturated);
  modport slave(input in_valid, quotient, step, out_ready, output in_ready, out_valid, recon, saturated);
endinterface

// File: rtl/dequant_reconstruct_mul_core.sv
// shift_add_mul_core: fixed-latency iterative multiplier, one multiplicand bit per cycle
module shift_add_mul_core #(
  parameter int QW = 6,
  parameter int SW = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [QW-1:0] mcand,
  input  logic [SW-1:0] mplier,
  output logic busy,
  output logic done,
  output logic [QW+SW:0] acc,
  output logic [SW-1:0] step_q
);
  localparam int AW = QW + SW + 1;
  localparam int CW = $clog2(QW) + 1;
  logic [QW-1:0] mcand_q;
  logic [CW-1:0] cnt;
  assign done = busy && cnt == CW'(QW - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      step_q <= '0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      mcand_q <= mcand;
      step_q <= mplier;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (mcand_q[0]) acc <= acc + (AW'(step_q) << cnt);
      mcand_q <= mcand_q >> 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/dequant_reconstruct.sv
// dequant_reconstruct: rebuilds level*step + step/2, clamped to the output width
module dequant_reconstruct
  import quant_pkg::*;
#(
  parameter int QUOT_WIDTH = quant_pkg::QUOT_WIDTH,
  parameter int STEP_WIDTH = quant_pkg::STEP_WIDTH,
  parameter int OUT_WIDTH = quant_pkg::OUT_WIDTH
) (
  input logic clk,
  input logic rst_n,
  dequant_reconstruct_if.slave bus
);
  localparam int AW = QUOT_WIDTH + STEP_WIDTH + 1;
  state_t state, state_n;
  logic [AW-1:0] acc, sum;
  logic [STEP_WIDTH-1:0] step_q;
  logic busy, done, start, over;
  logic [OUT_WIDTH-1:0] recon_q;
  logic sat_q;
  assign start = state == IDLE && bus.in_valid && !busy;
  shift_add_mul_core #(.QW(QUOT_WIDTH), .SW(STEP_WIDTH)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mcand(bus.quotient),
    .mplier(bus.step),
    .busy(busy),
    .done(done),
    .acc(acc),
    .step_q(step_q)
  );
  assign sum = acc + AW'(step_q >> 1);
  assign over = |sum[AW-1:OUT_WIDTH];
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = start ? MUL : IDLE;
      MUL: state_n = done ? FIN : MUL;
      FIN: state_n = DONE;
      DONE: state_n = bus.out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      recon_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == FIN) begin
        recon_q <= over ? '1 : sum[OUT_WIDTH-1:0];
        sat_q <= over;
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.recon = recon_q;
  assign bus.saturated = sat_q;
endmodule

// File: tb/tb_dequant_reconstruct.sv
// tb_dequant_reconstruct: scoreboard against level*step + step/2 with saturation, plus directed pins
module tb_dequant_reconstruct;
  import quant_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dequant_reconstruct_if #(.QUOT_WIDTH(QUOT_WIDTH), .STEP_WIDTH(STEP_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();
  dequant_reconstruct dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int r; bit s; int c;} exp_t;
  exp_t sb[$];
  int rises[$];
  int checks = 0, errors = 0, cyc = 0;
  int ma, mb, mv, last_r = 0, last_s = 0;
  bit head_seen = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      head_seen = 0;
      last_r = 0;
      last_s = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        ma = bus.quotient;
        mb = bus.step;
        mv = ma * mb + mb / 2;
        sb.push_back('{mv > OUT_MAX ? OUT_MAX : mv, mv > OUT_MAX, cyc});
      end
      if (bus.out_valid) begin
        chk("scoreboard occupancy", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          chk("recon", bus.recon, sb[0].r);
          chk("saturated", bus.saturated, sb[0].s);
          if (!head_seen) begin
            chk("latency", cyc - sb[0].c, QUOT_WIDTH + 2);
            rises.push_back(cyc);
            head_seen = 1;
          end
          if (bus.out_ready) begin
            void'(sb.pop_front());
            head_seen = 0;
          end
        end
        chk("in_ready low in DONE", bus.in_ready, 0);
        last_r = bus.recon;
        last_s = bus.saturated;
      end else begin
        chk("recon hold", bus.recon, last_r);
        chk("saturated hold", bus.saturated, last_s);
      end
    end
  end
  task automatic send(int q, int s, bit hold);
    bus.quotient = q[QUOT_WIDTH-1:0];
    bus.step = s[STEP_WIDTH-1:0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    chk("input accepted", bus.in_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(int r, int s);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("out_valid arrives", bus.out_valid, 1);
    chk("recon literal", bus.recon, r);
    chk("saturated literal", bus.saturated, s);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.quotient = '0;
    bus.step = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset recon", bus.recon, 0);
    chk("reset saturated", bus.saturated, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(5, 100, 0);
    wait_out(550, 0);
    @(posedge clk);
    #1;
    chk("in_ready after out handshake", bus.in_ready, 1);
    chk("out_valid after out handshake", bus.out_valid, 0);
    send(63, 511, 0);
    wait_out(1023, 1);
    @(posedge clk);
    #1;
    send(0, 0, 0);
    wait_out(0, 0);
    @(posedge clk);
    #1;
    send(0, 9, 0);
    wait_out(4, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(3, 7, 0);
    bus.quotient = 6'd1;
    bus.step = 9'd2;
    bus.in_valid = 1'b1;
    wait_out(24, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall out_valid", bus.out_valid, 1);
      chk("stall recon", bus.recon, 24);
      chk("stall in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(1, 2, 0);
    wait_out(3, 0);
    @(posedge clk);
    #1;
    send(4, 50, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", bus.in_ready, 1);
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort recon", bus.recon, 0);
    chk("abort saturated", bus.saturated, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no output after abort", bus.out_valid, 0);
    end
    send(2, 10, 0);
    wait_out(25, 0);
    @(posedge clk);
    #1;
    rises.delete();
    send(7, 33, 1);
    send(20, 45, 1);
    send(63, 1, 0);
    for (int i = 0; i < 80 && rises.size() < 3; i++) @(negedge clk);
    chk("three streamed results", rises.size(), 3);
    if (rises.size() >= 3) begin
      chk("spacing 1", rises[1] - rises[0], QUOT_WIDTH + 3);
      chk("spacing 2", rises[2] - rises[1], QUOT_WIDTH + 3);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = $urandom_range(0, 1);
      bus.quotient = ($urandom_range(0, 3) == 0) ? '1 : QUOT_WIDTH'($urandom);
      bus.step = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? '0 : '1) : STEP_WIDTH'($urandom);
      bus.out_ready = $urandom_range(0, 2) != 0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
